// File: rtl/ripplecnt_pkg.sv
// ripplecnt_pkg: shared types and widths for the ripple counter reader.
package ripplecnt_pkg;

  // Reader control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } rcr_state_t;

  // Largest TIMEOUT the reader accepts; the timeout counter is sized from it
  localparam int TIMEOUT_MAX = 255;
  localparam int T_W         = $clog2(TIMEOUT_MAX + 1);

  // Match counter holds values up to STABLE-1, with STABLE at most 8
  localparam int M_W = 4;

endpackage

// File: rtl/bus_sync2.sv
// bus_sync2: per-bit two-flop synchroniser with asynchronous active-low clear.
// Each bit is synchronised independently; a multi-bit bus may therefore be
// torn on the output, which the consumer is expected to tolerate.
module bus_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         aclr_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    logic meta_reg;
    logic sync_reg;

    // Two-stage chain for one bit of the bus
    always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= d[gi];
        sync_reg <= meta_reg;
      end
    end

    assign q[gi] = sync_reg;
  end

endmodule

// File: rtl/ripplecnt_reader.sv
// ripplecnt_reader: reads a free-running ripple counter bus, accepting a value
// only after STABLE identical synchronised samples, and returns the value plus
// the modular distance travelled since the previous good read.
module ripplecnt_reader
  import ripplecnt_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int STABLE  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic [DWIDTH-1:0] cnt_i,
  input  logic              dir,
  input  logic              req,
  output logic              busy,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic [DWIDTH-1:0] rd_delta,
  output logic              rd_err
);

  rcr_state_t        state_reg;
  logic [DWIDTH-1:0] sync2;
  logic [DWIDTH-1:0] ref_reg;
  logic [DWIDTH-1:0] last_reg;
  logic [DWIDTH-1:0] data_reg;
  logic [DWIDTH-1:0] delta_reg;
  logic [M_W-1:0]    m_reg;
  logic [T_W-1:0]    t_reg;
  logic              busy_reg;
  logic              valid_reg;
  logic              err_reg;

  logic              sample_new;
  logic              stable_hit;
  logic              timeout_hit;
  logic [DWIDTH-1:0] delta_next;

  bus_sync2 #(.W(DWIDTH)) u_sync (
    .clk    (clk),
    .aclr_n (aclr_n),
    .d      (cnt_i),
    .q      (sync2)
  );

  // Per-edge sampling decisions: restart the run, finish it, or give up
  always_comb begin
    sample_new  = (m_reg == '0) || (sync2 != ref_reg);
    stable_hit  = !sample_new && (m_reg == M_W'(STABLE - 1));
    timeout_hit = (t_reg == T_W'(TIMEOUT - 1));
    delta_next  = dir ? (ref_reg - last_reg) : (last_reg - ref_reg);
  end

  // Read FSM with registered result and status outputs
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_reg <= IDLE;
      ref_reg   <= '0;
      last_reg  <= '0;
      data_reg  <= '0;
      delta_reg <= '0;
      m_reg     <= '0;
      t_reg     <= '0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            state_reg <= SAMPLE;
            busy_reg  <= 1'b1;
            m_reg     <= '0;
            t_reg     <= '0;
          end
        end

        SAMPLE: begin
          t_reg <= t_reg + 1'b1;
          if (sample_new) begin
            ref_reg <= sync2;
            m_reg   <= M_W'(1);
          end else if (stable_hit) begin
            data_reg  <= ref_reg;
            delta_reg <= delta_next;
            err_reg   <= 1'b0;
            valid_reg <= 1'b1;
            state_reg <= HOLD;
          end else begin
            m_reg <= m_reg + 1'b1;
          end
          // A stable capture on the same edge takes priority over the timeout
          if (timeout_hit && !stable_hit) begin
            data_reg  <= sync2;
            delta_reg <= '0;
            err_reg   <= 1'b1;
            valid_reg <= 1'b1;
            state_reg <= HOLD;
          end
        end

        HOLD: begin
          if (valid_reg && rd_ready) begin
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
            // Error reads never move the reference point for the delta
            if (!err_reg) begin
              last_reg <= data_reg;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign rd_valid = valid_reg;
  assign rd_data  = data_reg;
  assign rd_delta = delta_reg;
  assign rd_err   = err_reg;

endmodule
